// File: rtl/i2s_rx_if.sv
// Signal bundle for the I2S receiver: serial pins from the codec and decoded stereo samples.
// The master modport is the receiver that produces samples; the slave modport drives the pins and reads the samples.
interface i2s_rx_if #(
    parameter int DATA_W = 24
);
    logic                     I2S_sclk;
    logic                     I2S_ws;
    logic                     I2S_data;
    logic signed [DATA_W-1:0] lft_chnnl;
    logic signed [DATA_W-1:0] rght_chnnl;
    logic                     vld;
    logic                     frm_err;

    modport master (
        input  I2S_sclk, I2S_ws, I2S_data,
        output lft_chnnl, rght_chnnl, vld, frm_err
    );

    modport slave (
        output I2S_sclk, I2S_ws, I2S_data,
        input  lft_chnnl, rght_chnnl, vld, frm_err
    );
endinterface

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples sclk/ws/data in the clk domain and decodes MSB-first stereo frames.
// A frame is published only after both channels are captured and both phases are long enough.
module i2s_rx #(
    parameter int DATA_W   = 24,
    parameter int MIN_BITS = 24
) (
    input  logic         clk,
    input  logic         rst,
    i2s_rx_if.master     bus
);
    localparam int CNT_W = $clog2(MIN_BITS + DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_BITS - 1);

    typedef enum logic [2:0] {SYNC, LEFT, WAIT_R, RIGHT, WAIT_L} state_t;

    logic [2:0] pin_raw;
    logic [2:0] pin_sync;
    assign pin_raw = {bus.I2S_sclk, bus.I2S_ws, bus.I2S_data};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= pin_raw[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign pin_sync[gi] = sync_reg;
        end
    endgenerate

    logic                     sclk_d_reg;
    logic                     ws_prev_reg;
    state_t                   state_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic [DATA_W-1:0]        left_sr_reg;
    logic [DATA_W-1:0]        right_sr_reg;
    logic signed [DATA_W-1:0] lft_reg;
    logic signed [DATA_W-1:0] rght_reg;
    logic                     vld_reg;
    logic                     frm_err_reg;
    logic                     upd_pending_reg;

    logic             sclk_rise;
    logic             ws_smp;
    logic             data_smp;
    logic             ws_edge;
    logic [CNT_W-1:0] cnt_inc;
    logic             phase_ok;

    assign sclk_rise = pin_sync[2] & ~sclk_d_reg;
    assign ws_smp    = pin_sync[1];
    assign data_smp  = pin_sync[0];
    assign ws_edge   = sclk_rise && (ws_smp != ws_prev_reg);
    assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
    // cnt_reg counts rises after the phase-opening edge, so the closing edge makes the phase cnt_reg+1 long
    assign phase_ok  = (cnt_reg >= MIN_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d_reg      <= 1'b0;
            ws_prev_reg     <= 1'b0;
            state_reg       <= SYNC;
            cnt_reg         <= '0;
            left_sr_reg     <= '0;
            right_sr_reg    <= '0;
            lft_reg         <= '0;
            rght_reg        <= '0;
            vld_reg         <= 1'b0;
            frm_err_reg     <= 1'b0;
            upd_pending_reg <= 1'b0;
        end else begin
            sclk_d_reg      <= pin_sync[2];
            vld_reg         <= 1'b0;
            frm_err_reg     <= 1'b0;
            upd_pending_reg <= 1'b0;
            if (upd_pending_reg) begin
                lft_reg  <= left_sr_reg;
                rght_reg <= right_sr_reg;
                vld_reg  <= 1'b1;
            end
            if (sclk_rise) begin
                ws_prev_reg <= ws_smp;
                case (state_reg)
                    SYNC: begin
                        if (ws_edge && !ws_smp) begin
                            state_reg <= LEFT;
                            cnt_reg   <= '0;
                        end
                    end
                    LEFT: begin
                        // With minimum-length phases the LSB arrives on the edge that opens the next phase
                        if (ws_edge) begin
                            if (cnt_reg == LAST_BIT && phase_ok) begin
                                left_sr_reg <= {left_sr_reg[DATA_W-2:0], data_smp};
                                state_reg   <= RIGHT;
                                cnt_reg     <= '0;
                            end else begin
                                frm_err_reg <= 1'b1;
                                state_reg   <= SYNC;
                            end
                        end else begin
                            left_sr_reg <= {left_sr_reg[DATA_W-2:0], data_smp};
                            cnt_reg     <= cnt_inc;
                            if (cnt_reg == LAST_BIT) state_reg <= WAIT_R;
                        end
                    end
                    WAIT_R: begin
                        if (ws_edge) begin
                            if (phase_ok) begin
                                state_reg <= RIGHT;
                                cnt_reg   <= '0;
                            end else begin
                                frm_err_reg <= 1'b1;
                                state_reg   <= SYNC;
                            end
                        end else begin
                            cnt_reg <= cnt_inc;
                        end
                    end
                    RIGHT: begin
                        if (ws_edge) begin
                            if (cnt_reg == LAST_BIT && phase_ok) begin
                                right_sr_reg    <= {right_sr_reg[DATA_W-2:0], data_smp};
                                upd_pending_reg <= 1'b1;
                                state_reg       <= LEFT;
                                cnt_reg         <= '0;
                            end else begin
                                frm_err_reg <= 1'b1;
                                state_reg   <= SYNC;
                            end
                        end else begin
                            right_sr_reg <= {right_sr_reg[DATA_W-2:0], data_smp};
                            cnt_reg      <= cnt_inc;
                            if (cnt_reg == LAST_BIT) begin
                                upd_pending_reg <= 1'b1;
                                state_reg       <= WAIT_L;
                            end
                        end
                    end
                    WAIT_L: begin
                        if (ws_edge) begin
                            if (phase_ok) begin
                                state_reg <= LEFT;
                                cnt_reg   <= '0;
                            end else begin
                                frm_err_reg <= 1'b1;
                                state_reg   <= SYNC;
                            end
                        end else begin
                            cnt_reg <= cnt_inc;
                        end
                    end
                    default: state_reg <= SYNC;
                endcase
            end
        end
    end

    assign bus.lft_chnnl  = lft_reg;
    assign bus.rght_chnnl = rght_reg;
    assign bus.vld        = vld_reg;
    assign bus.frm_err    = frm_err_reg;
endmodule

// File: tb/tb_i2s_rx.sv
// Randomized bench for i2s_rx: an I2S transmitter model plus a frame-level expectation queue.
// A frame is expected to be reported iff both its phases are at least MIN_BITS sclk periods long.
module tb_i2s_rx;
    localparam int DW = 24;
    localparam int MB = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2s_rx_if #(.DATA_W(DW)) bus ();
    i2s_rx #(.DATA_W(DW), .MIN_BITS(MB)) dut (.clk(clk), .rst(rst), .bus(bus));

    int chk_cnt = 0;
    int pass_cnt = 0;
    int vld_cnt = 0;
    int err_cnt = 0;
    int hold_viol = 0;
    int overlap_viol = 0;
    int exp_vld = 0;
    int exp_err = 0;
    int half_ns = 160;
    logic carry = 1'b0;
    logic [DW-1:0] exp_l_q[$];
    logic [DW-1:0] exp_r_q[$];
    logic [DW-1:0] prev_l, prev_r, mon_l, mon_r;

    // Monitor: checks every vld against the expectation queue and tallies frm_err
    always @(negedge clk) begin
        if (rst) begin
            prev_l = '0;
            prev_r = '0;
        end else begin
            if (bus.vld && bus.frm_err) overlap_viol++;
            if (bus.frm_err) err_cnt++;
            if (bus.vld) begin
                vld_cnt++;
                chk_cnt++;
                if (exp_l_q.size() == 0) begin
                    $display("FAIL unexpected_vld: got l=%h r=%h, required no vld", bus.lft_chnnl, bus.rght_chnnl);
                end else begin
                    mon_l = exp_l_q.pop_front();
                    mon_r = exp_r_q.pop_front();
                    if (bus.lft_chnnl !== mon_l || bus.rght_chnnl !== mon_r)
                        $display("FAIL frame_value: got l=%h r=%h, required l=%h r=%h",
                                 bus.lft_chnnl, bus.rght_chnnl, mon_l, mon_r);
                    else begin
                        pass_cnt++;
                        $display("frame ok l=%h r=%h", mon_l, mon_r);
                    end
                end
            end else if (bus.lft_chnnl !== prev_l || bus.rght_chnnl !== prev_r) begin
                hold_viol++;
            end
            prev_l = bus.lft_chnnl;
            prev_r = bus.rght_chnnl;
        end
    end

    task automatic send_phase(input logic w, input logic [DW-1:0] s, input int n);
        logic d;
        for (int k = 0; k < n; k++) begin
            if (k == 0) d = carry;
            else if (k <= DW) d = s[DW-k];
            else d = 1'b0;
            bus.I2S_ws = w;
            bus.I2S_data = d;
            #(half_ns) bus.I2S_sclk = 1'b1;
            #(half_ns) bus.I2S_sclk = 1'b0;
        end
        carry = (n <= DW) ? s[DW-n] : 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int nl, input int nr);
        if (nl >= MB && nr >= MB) begin
            exp_l_q.push_back(l);
            exp_r_q.push_back(r);
            exp_vld++;
        end else begin
            exp_err++;
        end
        send_phase(1'b0, l, nl);
        send_phase(1'b1, r, nr);
    endtask

    task automatic start_test(input int hp);
        half_ns = hp;
        bus.I2S_sclk = 1'b0;
        bus.I2S_ws = 1'b0;
        bus.I2S_data = 1'b0;
        rst = 1'b1;
        #40 rst = 1'b0;
        #20;
        vld_cnt = 0;
        err_cnt = 0;
        exp_vld = 0;
        exp_err = 0;
        exp_l_q.delete();
        exp_r_q.delete();
        carry = 1'b0;
        send_phase(1'b0, '0, 2);
        send_phase(1'b1, DW'($urandom), 6);
    endtask

    task automatic finish_frames();
        send_phase(1'b0, '0, 3);
        repeat (20) @(posedge clk);
    endtask

    task automatic test_reset();
        #3;
        bus.I2S_sclk = 1'b1;
        bus.I2S_ws = 1'b1;
        bus.I2S_data = 1'b1;
        rst = 1'b1;
        #40;
        chk_cnt++; if (bus.lft_chnnl !== '0) $display("FAIL reset_lft: got %h required 0", bus.lft_chnnl); else pass_cnt++;
        chk_cnt++; if (bus.rght_chnnl !== '0) $display("FAIL reset_rght: got %h required 0", bus.rght_chnnl); else pass_cnt++;
        chk_cnt++; if (bus.vld !== 1'b0) $display("FAIL reset_vld: got %b required 0", bus.vld); else pass_cnt++;
        chk_cnt++; if (bus.frm_err !== 1'b0) $display("FAIL reset_frm_err: got %b required 0", bus.frm_err); else pass_cnt++;
        $display("reset state checked");
    endtask

    task automatic test_basic();
        start_test(160);
        for (int i = 0; i < 3; i++) send_frame(24'h123456, 24'hFEDCBA, 32, 32);
        finish_frames();
        chk_cnt++; if (vld_cnt !== exp_vld) $display("FAIL basic_vld_count: got %0d required %0d", vld_cnt, exp_vld); else pass_cnt++;
        chk_cnt++; if (err_cnt !== 0) $display("FAIL basic_frm_err: got %0d required 0", err_cnt); else pass_cnt++;
        chk_cnt++; if (bus.lft_chnnl !== 24'h123456) $display("FAIL basic_lft: got %h required 123456", bus.lft_chnnl); else pass_cnt++;
        chk_cnt++; if (bus.rght_chnnl !== 24'hFEDCBA) $display("FAIL basic_rght: got %h required fedcba", bus.rght_chnnl); else pass_cnt++;
    endtask

    task automatic test_first_edge();
        logic [DW-1:0] l, r;
        start_test(80);
        chk_cnt++; if (vld_cnt !== 0) $display("FAIL first_edge_no_vld: got %0d required 0", vld_cnt); else pass_cnt++;
        l = DW'($urandom);
        r = DW'($urandom);
        send_frame(l, r, 32, 32);
        finish_frames();
        chk_cnt++; if (vld_cnt !== exp_vld) $display("FAIL first_edge_vld_count: got %0d required %0d", vld_cnt, exp_vld); else pass_cnt++;
        chk_cnt++; if (err_cnt !== 0) $display("FAIL first_edge_frm_err: got %0d required 0", err_cnt); else pass_cnt++;
    endtask

    task automatic test_truncated();
        logic [DW-1:0] l, r;
        start_test(80);
        l = DW'($urandom);
        r = DW'($urandom);
        send_frame(l, r, 32, 32);
        send_frame(DW'($urandom), DW'($urandom), 10, 32);
        chk_cnt++; if (err_cnt !== 1) $display("FAIL trunc_frm_err: got %0d required 1", err_cnt); else pass_cnt++;
        chk_cnt++; if (bus.lft_chnnl !== l || bus.rght_chnnl !== r)
            $display("FAIL trunc_hold: got l=%h r=%h required l=%h r=%h", bus.lft_chnnl, bus.rght_chnnl, l, r);
        else pass_cnt++;
        send_frame(24'h000001, 24'h800000, 32, 32);
        finish_frames();
        chk_cnt++; if (vld_cnt !== exp_vld) $display("FAIL trunc_vld_count: got %0d required %0d", vld_cnt, exp_vld); else pass_cnt++;
        chk_cnt++; if (err_cnt !== exp_err) $display("FAIL trunc_err_count: got %0d required %0d", err_cnt, exp_err); else pass_cnt++;
        chk_cnt++; if (bus.lft_chnnl !== 24'h000001 || bus.rght_chnnl !== 24'h800000)
            $display("FAIL trunc_final: got l=%h r=%h required l=000001 r=800000", bus.lft_chnnl, bus.rght_chnnl);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] l, r;
        start_test(80);
        send_frame(DW'($urandom) | 24'h1, DW'($urandom) | 24'h1, 32, 32);
        send_phase(1'b0, 24'h7FFFFF, 32);
        send_phase(1'b1, 24'h000000, 12);
        rst = 1'b1;
        #20;
        chk_cnt++; if (bus.lft_chnnl !== '0 || bus.rght_chnnl !== '0)
            $display("FAIL rst_mid_during: got l=%h r=%h required 0", bus.lft_chnnl, bus.rght_chnnl);
        else pass_cnt++;
        #20 rst = 1'b0;
        send_phase(1'b1, 24'h000000, 20);
        chk_cnt++; if (bus.lft_chnnl !== '0 || bus.rght_chnnl !== '0)
            $display("FAIL rst_mid_after: got l=%h r=%h required 0", bus.lft_chnnl, bus.rght_chnnl);
        else pass_cnt++;
        chk_cnt++; if (vld_cnt !== exp_vld) $display("FAIL rst_mid_no_vld: got %0d required %0d", vld_cnt, exp_vld); else pass_cnt++;
        l = DW'($urandom);
        r = DW'($urandom);
        send_frame(l, r, 32, 32);
        finish_frames();
        chk_cnt++; if (vld_cnt !== exp_vld) $display("FAIL rst_mid_vld_count: got %0d required %0d", vld_cnt, exp_vld); else pass_cnt++;
        chk_cnt++; if (bus.lft_chnnl !== l || bus.rght_chnnl !== r)
            $display("FAIL rst_mid_final: got l=%h r=%h required l=%h r=%h", bus.lft_chnnl, bus.rght_chnnl, l, r);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] base;
        start_test(40);
        base = DW'($urandom);
        for (int i = 0; i < 100; i++)
            send_frame(base + DW'(2 * i), base + DW'(2 * i + 1),
                       int'($urandom_range(24, 28)), int'($urandom_range(24, 28)));
        finish_frames();
        chk_cnt++; if (vld_cnt !== 100) $display("FAIL b2b_vld_count: got %0d required 100", vld_cnt); else pass_cnt++;
        chk_cnt++; if (err_cnt !== 0) $display("FAIL b2b_frm_err: got %0d required 0", err_cnt); else pass_cnt++;
        chk_cnt++; if (exp_l_q.size() !== 0) $display("FAIL b2b_pending: got %0d unreported required 0", exp_l_q.size()); else pass_cnt++;
    endtask

    task automatic test_boundary();
        start_test(40);
        for (int i = 0; i < 4; i++) send_frame(DW'($urandom), DW'($urandom), MB, MB);
        finish_frames();
        chk_cnt++; if (vld_cnt !== exp_vld) $display("FAIL bound24_vld: got %0d required %0d", vld_cnt, exp_vld); else pass_cnt++;
        chk_cnt++; if (err_cnt !== 0) $display("FAIL bound24_frm_err: got %0d required 0", err_cnt); else pass_cnt++;
        start_test(40);
        for (int i = 0; i < 4; i++) send_frame(DW'($urandom), DW'($urandom), MB - 1, MB - 1);
        finish_frames();
        chk_cnt++; if (vld_cnt !== 0) $display("FAIL bound23_vld: got %0d required 0", vld_cnt); else pass_cnt++;
        chk_cnt++; if (err_cnt !== exp_err) $display("FAIL bound23_frm_err: got %0d required %0d", err_cnt, exp_err); else pass_cnt++;
    endtask

    task automatic test_invariants();
        chk_cnt++; if (hold_viol !== 0) $display("FAIL output_hold: got %0d changes without vld required 0", hold_viol); else pass_cnt++;
        chk_cnt++; if (overlap_viol !== 0) $display("FAIL vld_err_overlap: got %0d cycles required 0", overlap_viol); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_first_edge();
        test_truncated();
        test_reset_mid();
        test_back_to_back();
        test_boundary();
        test_invariants();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 24, giving the captured sample width per channel.
REQ-002 The block SHALL have parameter MIN_BITS, default 24, giving the minimum sclk rises per ws phase for a legal frame (MIN_BITS >= DATA_W).
REQ-003 Port clk, input, 1: system clock; all state SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous assert, active-high.
REQ-005 Port I2S_sclk, input, 1: bit clock from the RN52, asynchronous to clk.
REQ-006 Port I2S_ws, input, 1: word select (0 = left, 1 = right), asynchronous to clk.
REQ-007 Port I2S_data, input, 1: serial audio, MSB first, asynchronous to clk.
REQ-008 Port lft_chnnl, output, DATA_W: last complete left sample, signed two's complement.
REQ-009 Port rght_chnnl, output, DATA_W: last complete right sample, signed two's complement.
REQ-010 Port vld, output, 1: one-clk pulse marking an lft_chnnl/rght_chnnl update.
REQ-011 Port frm_err, output, 1: one-clk pulse marking a discarded malformed frame.

Function
REQ-012 I2S_sclk, I2S_ws and I2S_data SHALL each pass through a 2-flop synchronizer, plus a third sclk flop for edge detection.
REQ-013 sclk_rise SHALL be (sclk sync stage 2 high and stage 3 low); ws and data SHALL be sampled only on clk cycles where sclk_rise is high.
REQ-014 A ws transition SHALL be detected at an sclk_rise where sampled ws differs from ws sampled at the previous sclk_rise.
REQ-015 FSM states SHALL be SYNC, LEFT, WAIT_R, RIGHT and WAIT_L.
REQ-016 SYNC SHALL ignore all data until a ws 1->0 transition, then enter LEFT with bit counter cleared.
REQ-017 In LEFT, the transition sclk_rise SHALL NOT be captured (I2S one-bit delay); the next DATA_W sclk_rises SHALL shift data MSB-first into a left shadow register.
REQ-018 After DATA_W bits in LEFT, the FSM SHALL enter WAIT_R, ignoring further bits until a ws 0->1 transition, then enter RIGHT.
REQ-019 RIGHT SHALL capture DATA_W bits into a right shift register using the same one-bit-delay rule as LEFT.
REQ-020 On the clk edge after right bit 0 is shifted in, lft_chnnl SHALL load the left shadow, rght_chnnl SHALL load the right shift register, and vld SHALL be high for exactly that one clk.
REQ-021 After that update, the FSM SHALL enter WAIT_L; a ws 1->0 transition in WAIT_L SHALL enter LEFT directly, with no return to SYNC.
REQ-022 A ws transition in LEFT or RIGHT before DATA_W bits are captured SHALL pulse frm_err for one clk and enter SYNC. Outputs SHALL be unchanged and vld SHALL NOT pulse.
REQ-023 A ws transition in WAIT_R or WAIT_L after fewer than MIN_BITS total sclk_rises in the current phase SHALL pulse frm_err and enter SYNC.
REQ-024 The per-phase bit counter SHALL saturate at its maximum value and never wrap.
REQ-025 lft_chnnl and rght_chnnl SHALL hold their values between vld pulses.
REQ-026 vld and frm_err SHALL never be high in the same cycle.

Reset
REQ-027 Asserting rst SHALL immediately force state SYNC, clear all synchronizer flops, counters, shadow and shift registers, set lft_chnnl and rght_chnnl to 0, and set vld and frm_err to 0.
REQ-028 rst asserted mid-frame SHALL discard the partial frame; after rst deasserts, the first vld SHALL occur only after a full left+right frame that starts at a ws 1->0 transition.

Verification
REQ-029 Scenario: bench drives sclk = clk/32 and 32-bit phases with left 24'h123456 and right 24'hFEDCBA -> first vld after the first full frame; lft_chnnl = 24'h123456, rght_chnnl = 24'hFEDCBA; exactly one vld per frame.
REQ-030 Scenario: first ws edge seen after reset is 0->1 -> no capture and no vld until the next 1->0 edge; the next full frame is reported correctly.
REQ-031 Scenario: left phase truncated to 10 sclk periods -> one frm_err pulse, no vld, outputs retain their prior values; the following good frame 24'h000001/24'h800000 -> vld with those values.
REQ-032 Scenario: rst pulsed during the right phase of a frame carrying 24'h7FFFFF/24'h000000 -> outputs 0 during and after reset, no vld for that frame; the next full frame is reported correctly.
REQ-033 Scenario: 100 back-to-back frames with incrementing samples -> 100 vld pulses, each matching the expected pair, zero frm_err.
REQ-034 Scenario: 24-bit phases (MIN_BITS = 24 boundary) -> accepted with no frm_err; 23-bit phases -> frm_err on every frame.
